// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU beside the EX stage.
// One quotient bit per cycle; {remainder, quotient} is returned for HI/LO.
module ex_div #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               start,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready
);

  typedef enum logic [1:0] {
    S_FREE,
    S_BYZERO,
    S_ON,
    S_END
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               sdiv_q, sdiv_d;
  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               rdy_q, rdy_d;

  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic               fits;
  logic               quo_neg;
  logic               rem_neg;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               last;

  // quo_q holds unconsumed dividend bits; quotient bits shift in behind them
  assign trial   = {rem_q, quo_q[WIDTH-1]};
  assign diff    = trial - {1'b0, dvs_q};
  assign fits    = ~diff[WIDTH];
  assign quo_neg = sdiv_q & (s1_q ^ s2_q);
  assign rem_neg = sdiv_q & s1_q;
  assign quo_fix = quo_neg ? -quo_q : quo_q;
  assign rem_fix = rem_neg ? -rem_q : rem_q;
  assign last    = (cnt_q == CNT_W'(WIDTH));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    sdiv_d  = sdiv_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    res_d   = res_q;
    rdy_d   = rdy_q;
    unique case (state_q)
      S_FREE: begin
        res_d = '0;
        rdy_d = 1'b0;
        if (start && !annul) begin
          if (opdata2 == '0) begin
            state_d = S_BYZERO;
          end else begin
            state_d = S_ON;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = (signed_div && opdata1[WIDTH-1])
                      ? -opdata1 : opdata1;
            dvs_d   = (signed_div && opdata2[WIDTH-1])
                      ? -opdata2 : opdata2;
            sdiv_d  = signed_div;
            s1_d    = opdata1[WIDTH-1];
            s2_d    = opdata2[WIDTH-1];
          end
        end
      end
      S_BYZERO: begin
        state_d = S_END;
        res_d   = '0;
        rdy_d   = 1'b1;
      end
      S_ON: begin
        if (!last) begin
          rem_d = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], fits};
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = S_END;
          res_d   = {rem_fix, quo_fix};
          rdy_d   = 1'b1;
        end
      end
      S_END: begin
        if (!start) begin
          state_d = S_FREE;
          res_d   = '0;
          rdy_d   = 1'b0;
        end
      end
    endcase
    if (annul && state_q != S_FREE) begin
      state_d = S_FREE;
      cnt_d   = '0;
      res_d   = '0;
      rdy_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FREE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      sdiv_q  <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      res_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      sdiv_q  <= sdiv_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      res_q   <= res_d;
      rdy_q   <= rdy_d;
    end
  end

  assign result = res_q;
  assign ready  = rdy_q;

endmodule
